mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TAG_W, default 4, width of load tag.
REQ-002 Parameter TIMEOUT, default 15, max cycles an operation waits for RAM status.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 ld_req / ld_addr / ld_tag  in  1/32/TAG_W  load request; level, held with stable addr/tag until ld_ack.
REQ-006 ld_ack  out  1  one-cycle pulse: load accepted.
REQ-007 ld_valid / ld_data / ld_tag_out / ld_err  out  1/32/TAG_W/1  load result, valid for one cycle.
REQ-008 st_req / st_addr / st_data  in  1/32/32  store request; level, held stable until st_ack.
REQ-009 st_ack / st_done / st_err  out  1/1/1  one-cycle pulses: store accepted / completed / timed out.
REQ-010 ram_addr / ram_wdata  out  32/32  registered RAM address and write data.
REQ-011 ram_nRD / ram_nWR  out  1/1  registered RAM strobes, active-low.
REQ-012 ram_rdata / ram_readStatus / ram_writeStatus  in  32/1/1  RAM read data and completion flags.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be INIT, IDLE, RD, WR, GAP.
REQ-015 INIT: cycle counter counts 0..11; at 11, go to IDLE; strobes held high.
REQ-016 IDLE, no request: remain in IDLE, outputs unchanged except pulses cleared.
REQ-017 IDLE, only one request: grant it; both requesting: grant the one not in last_grant, then update last_grant.
REQ-018 Grant of a load: latch ram_addr=ld_addr and the tag, pulse ld_ack, drive ram_nRD=0 from the next cycle, enter RD, clear counter.
REQ-019 Grant of a store: latch ram_addr=st_addr and ram_wdata=st_data, pulse st_ack, drive ram_nWR=0, enter WR, clear counter.
REQ-020 At most one strobe low at any time; ram_nRD and ram_nWR never both 0.
REQ-021 ram_addr and ram_wdata SHALL NOT change while in RD, WR or GAP.
REQ-022 RD: when ram_readStatus=1 is sampled, capture ram_rdata into ld_data, pulse ld_valid with ld_tag_out = latched tag and ld_err=0, set ram_nRD=1, go to GAP.
REQ-023 WR: when ram_writeStatus=1 is sampled, pulse st_done, set ram_nWR=1, go to GAP.
REQ-024 RD/WR: counter increments each cycle; reaching TIMEOUT without status pulses ld_valid+ld_err (ld_data=0) or st_err, releases the strobe, and goes to GAP.
REQ-025 Status inputs SHALL be ignored outside the matching state (readStatus outside RD, writeStatus outside WR).
REQ-026 GAP: exactly one cycle with both strobes high, then IDLE; requests are not granted in GAP.
REQ-027 Latency: grant-cycle edge to result pulse = RAM status cycles + 1; minimum issue-to-issue spacing is op length + 2 cycles.
REQ-028 A request whose req drops before ack is not granted; a requester re-asserting req in the cycle after ack is treated as a new request.
REQ-029 Counter is 5 bits wide and saturates; it does not wrap.

Reset
REQ-030 nRST=0 SHALL immediately force: state INIT, counter 0, ram_nRD=1, ram_nWR=1, ram_addr=0, ram_wdata=0, ld_data=0, ld_tag_out=0, all pulses 0, busy=1, last_grant=store (first contention goes to load).
REQ-031 Reset asserted mid-operation drops the strobe at once; the INIT quiet period lets the RAM's internal counter finish before any new issue; no result pulse is produced for the aborted op.

Verification
REQ-032 Single load addr=0x8 tag=3, RAM returns 0xDEADBEEF after 10 cycles -> ld_ack once, ld_valid once with ld_data=0xDEADBEEF, ld_tag_out=3, ld_err=0, then GAP, then IDLE.
REQ-033 Single store addr=0x10 data=0x11223344, then load 0x10 -> st_done once, subsequent load returns 0x11223344.
REQ-034 ld_req and st_req both held for 4 ops -> grants alternate load, store, load, store; never two strobes low.
REQ-035 RAM status tied 0, load issued -> after TIMEOUT=15 cycles ld_valid=1 with ld_err=1, ld_data=0; next request accepted after GAP.
REQ-036 nRST pulsed low 5 cycles into a read -> ram_nRD=1 asynchronously, no ld_valid, busy=1 for 12 cycles after release, then a new load completes correctly.
REQ-037 Stray ram_readStatus=1 while in WR -> ignored; only st_done pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (load/store) arbiter onto a single asynchronous-handshake RAM.
// One operation in flight at a time; alternating priority on contention.
module mem_arbiter #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_ack,
  output logic             ld_valid,
  output logic [31:0]      ld_data,
  output logic [TAG_W-1:0] ld_tag_out,
  output logic             ld_err,
  input  logic             st_req,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_ack,
  output logic             st_done,
  output logic             st_err,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  output logic             ram_nRD,
  output logic             ram_nWR,
  input  logic [31:0]      ram_rdata,
  input  logic             ram_readStatus,
  input  logic             ram_writeStatus,
  output logic             busy
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR, S_GAP} state_t;

  localparam logic [5:0] TO_LIM = 6'(TIMEOUT);

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d, cnt_inc;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, ld_data_q, ld_data_d;
  logic [TAG_W-1:0]   tag_q, tag_d, tag_out_q, tag_out_d;
  logic               nrd_q, nrd_d, nwr_q, nwr_d;
  logic               ld_ack_q, ld_ack_d, ld_valid_q, ld_valid_d, ld_err_q, ld_err_d;
  logic               st_ack_q, st_ack_d, st_done_q, st_done_d, st_err_q, st_err_d;
  logic               last_st_q, last_st_d;
  logic               grant_ld, grant_st, timed_out;

  // Counter saturates at all-ones so a long stall can never wrap back under the limit.
  assign cnt_inc   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
  assign timed_out = {1'b0, cnt_inc} >= TO_LIM;
  assign grant_ld  = ld_req && (!st_req || last_st_q);
  assign grant_st  = st_req && !grant_ld;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ld_data_d  = ld_data_q;
    tag_d      = tag_q;
    tag_out_d  = tag_out_q;
    nrd_d      = nrd_q;
    nwr_d      = nwr_q;
    last_st_d  = last_st_q;
    ld_ack_d   = 1'b0;
    ld_valid_d = 1'b0;
    ld_err_d   = 1'b0;
    st_ack_d   = 1'b0;
    st_done_d  = 1'b0;
    st_err_d   = 1'b0;
    case (state_q)
      S_INIT: begin
        nrd_d = 1'b1;
        nwr_d = 1'b1;
        if (cnt_q == 5'd11) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_IDLE: begin
        if (grant_ld) begin
          addr_d    = ld_addr;
          tag_d     = ld_tag;
          ld_ack_d  = 1'b1;
          nrd_d     = 1'b0;
          last_st_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_RD;
        end else if (grant_st) begin
          addr_d    = st_addr;
          wdata_d   = st_data;
          st_ack_d  = 1'b1;
          nwr_d     = 1'b0;
          last_st_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_WR;
        end
      end
      S_RD: begin
        cnt_d = cnt_inc;
        if (ram_readStatus || timed_out) begin
          ld_data_d  = ram_readStatus ? ram_rdata : 32'h0;
          ld_err_d   = !ram_readStatus;
          ld_valid_d = 1'b1;
          tag_out_d  = tag_q;
          nrd_d      = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_WR: begin
        cnt_d = cnt_inc;
        if (ram_writeStatus || timed_out) begin
          st_done_d = ram_writeStatus;
          st_err_d  = !ram_writeStatus;
          nwr_d     = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        nrd_d   = 1'b1;
        nwr_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ld_data_q  <= '0;
      tag_q      <= '0;
      tag_out_q  <= '0;
      nrd_q      <= 1'b1;
      nwr_q      <= 1'b1;
      last_st_q  <= 1'b1;
      ld_ack_q   <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_err_q   <= 1'b0;
      st_ack_q   <= 1'b0;
      st_done_q  <= 1'b0;
      st_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ld_data_q  <= ld_data_d;
      tag_q      <= tag_d;
      tag_out_q  <= tag_out_d;
      nrd_q      <= nrd_d;
      nwr_q      <= nwr_d;
      last_st_q  <= last_st_d;
      ld_ack_q   <= ld_ack_d;
      ld_valid_q <= ld_valid_d;
      ld_err_q   <= ld_err_d;
      st_ack_q   <= st_ack_d;
      st_done_q  <= st_done_d;
      st_err_q   <= st_err_d;
    end
  end

  assign ld_ack     = ld_ack_q;
  assign ld_valid   = ld_valid_q;
  assign ld_data    = ld_data_q;
  assign ld_tag_out = tag_out_q;
  assign ld_err     = ld_err_q;
  assign st_ack     = st_ack_q;
  assign st_done    = st_done_q;
  assign st_err     = st_err_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_nRD    = nrd_q;
  assign ram_nWR    = nwr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed ops against a behavioural RAM;
// expected acks/results are queued at issue and checked by a negedge monitor.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nRST;
  logic        ld_req, st_req;
  logic [31:0] ld_addr, st_addr, st_data;
  logic [3:0]  ld_tag;
  logic        ld_ack, ld_valid, ld_err, st_ack, st_done, st_err;
  logic [31:0] ld_data, ram_addr, ram_wdata;
  logic [3:0]  ld_tag_out;
  logic        ram_nRD, ram_nWR, busy;
  logic [31:0] ram_rdata;
  logic        ram_readStatus, ram_writeStatus;

  mem_arbiter #(.TAG_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .nRST(nRST),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_tag(ld_tag), .ld_ack(ld_ack),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_tag_out(ld_tag_out), .ld_err(ld_err),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_ack(st_ack), .st_done(st_done), .st_err(st_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_nRD(ram_nRD), .ram_nWR(ram_nWR),
    .ram_rdata(ram_rdata), .ram_readStatus(ram_readStatus), .ram_writeStatus(ram_writeStatus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ld;
    logic [31:0] data;
    logic [3:0]  tag;
    bit          err;
  } res_t;

  res_t res_q[$];
  bit   ack_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Behavioural RAM: status one cycle after rd_lat/wr_lat strobe-low cycles (rd_lat=0: never).
  logic [31:0] mem [logic [31:0]];
  int rd_lat = 10, wr_lat = 4, rc = 0, wc = 0;
  bit stray = 1'b0;

  always @(negedge clk) begin
    ram_readStatus  = 1'b0;
    ram_writeStatus = 1'b0;
    if (!ram_nRD) begin
      rc++;
      if (rd_lat != 0 && rc == rd_lat) begin
        ram_rdata      = mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
        ram_readStatus = 1'b1;
      end
    end else rc = 0;
    if (!ram_nWR) begin
      wc++;
      if (stray && wc == 2) begin
        ram_rdata      = 32'hBAD0BAD0;
        ram_readStatus = 1'b1;
      end
      if (wc == wr_lat) begin
        mem[ram_addr]   = ram_wdata;
        ram_writeStatus = 1'b1;
      end
    end else wc = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT pulses an ack or a result.
  logic [31:0] prev_addr;
  bit          prev_low = 1'b0;
  always @(negedge clk) begin
    if (nRST) begin
      n_cmp++;
      if (!ram_nRD && !ram_nWR) begin
        n_fail++;
        $display("FAIL strobes: nRD=%b nWR=%b both low", ram_nRD, ram_nWR);
      end
      if (prev_low && (!ram_nRD || !ram_nWR)) begin
        n_cmp++;
        if (ram_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL addr_stable: got %h expected %h", ram_addr, prev_addr);
        end
      end
      prev_low  = !ram_nRD || !ram_nWR;
      prev_addr = ram_addr;
      if (ld_ack || st_ack) begin
        n_cmp++;
        if (ack_q.size() == 0) begin
          n_fail++;
          $display("FAIL ack: unexpected ld_ack=%b st_ack=%b", ld_ack, st_ack);
        end else begin
          bit e;
          e = ack_q.pop_front();
          if ((ld_ack && st_ack) || ld_ack != e) begin
            n_fail++;
            $display("FAIL ack: got ld_ack=%b st_ack=%b expected load=%b", ld_ack, st_ack, e);
          end
        end
      end
      if (ld_valid || st_done || st_err) begin
        n_cmp++;
        if (res_q.size() == 0) begin
          n_fail++;
          $display("FAIL result: unexpected ld_valid=%b st_done=%b st_err=%b", ld_valid, st_done, st_err);
        end else begin
          res_t e;
          e = res_q.pop_front();
          if (e.is_ld) begin
            if (!ld_valid || st_done || st_err || ld_data !== e.data || ld_tag_out !== e.tag || ld_err !== e.err) begin
              n_fail++;
              $display("FAIL load_result: got v=%b data=%h tag=%h err=%b expected data=%h tag=%h err=%b",
                       ld_valid, ld_data, ld_tag_out, ld_err, e.data, e.tag, e.err);
            end
          end else if (ld_valid || (st_done && st_err) || st_err !== e.err) begin
            n_fail++;
            $display("FAIL store_result: got ld_valid=%b done=%b err=%b expected err=%b",
                     ld_valid, st_done, st_err, e.err);
          end
        end
      end
    end else prev_low = 1'b0;
  end

  task automatic wait_init();
    int n = 0;
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (!busy) begin got = 1'b1; break; end
    end
    chk("init_cycles", got ? n : -1, 12);
  endtask

  task automatic wait_ack(input bit is_ld);
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (is_ld ? ld_ack : st_ack) begin got = 1'b1; break; end
    end
    chk("ack_wait", got, 1);
  endtask

  // After the result pulse: one GAP cycle (still busy, strobes high), then IDLE.
  task automatic wait_result_gap(input bit is_ld);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (is_ld ? ld_valid : (st_done || st_err)) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("result_wait", got, 1);
    chk("gap_busy", {busy, ram_nRD, ram_nWR}, 3'b111);
    @(negedge clk);
    chk("idle_after_gap", {busy, ram_nRD, ram_nWR}, 3'b011);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] t,
                         input logic [31:0] d, input bit err, input bit has_res);
    ack_q.push_back(1'b1);
    if (has_res) res_q.push_back('{1'b1, d, t, err});
    @(negedge clk);
    ld_addr = a; ld_tag = t; ld_req = 1'b1;
    wait_ack(1'b1);
    ld_req = 1'b0;
    if (has_res) wait_result_gap(1'b1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    ack_q.push_back(1'b0);
    res_q.push_back('{1'b0, 32'h0, 4'h0, 1'b0});
    @(negedge clk);
    st_addr = a; st_data = d; st_req = 1'b1;
    wait_ack(1'b0);
    st_req = 1'b0;
    wait_result_gap(1'b0);
  endtask

  initial begin
    nRST = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    ld_addr = '0; ld_tag = '0; st_addr = '0; st_data = '0;
    ram_rdata = '0; ram_readStatus = 1'b0; ram_writeStatus = 1'b0;
    mem[32'h8] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("rst_strobes_busy", {ram_nRD, ram_nWR, busy}, 3'b111);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_ld_data_tag", {ld_data, ld_tag_out} == 36'h0, 1);
    chk("rst_pulses", {ld_ack, ld_valid, ld_err, st_ack, st_done, st_err}, 6'b0);
    nRST = 1'b1;
    wait_init();

    do_load(32'h8, 4'd3, 32'hDEADBEEF, 1'b0, 1'b1);
    do_store(32'h10, 32'h11223344);
    rd_lat = 3;
    do_load(32'h10, 4'd1, 32'h11223344, 1'b0, 1'b1);

    rd_lat = 0;
    do_load(32'h30, 4'd7, 32'h0, 1'b1, 1'b1);
    rd_lat = 3;
    do_load(32'h10, 4'd2, 32'h11223344, 1'b0, 1'b1);

    // Stray readStatus during WR, plus a load request that drops before it could be granted.
    stray = 1'b1;
    fork
      do_store(32'h40, 32'hCAFEF00D);
      begin
        repeat (3) @(negedge clk);
        ld_addr = 32'h44; ld_req = 1'b1;
        @(negedge clk);
        ld_req = 1'b0;
      end
    join
    stray = 1'b0;

    // Reset five cycles into a read: no result for the aborted load.
    rd_lat = 10;
    do_load(32'h8, 4'd9, 32'h0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    chk("abort_nrd", {ram_nRD, busy, ld_valid}, 3'b110);
    chk("abort_addr", ram_addr, 32'h0);
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    wait_init();

    // Contention: both held; first contention after reset goes to load, then alternate.
    rd_lat = 3;
    ack_q.push_back(1'b1); ack_q.push_back(1'b0); ack_q.push_back(1'b1); ack_q.push_back(1'b0);
    res_q.push_back('{1'b1, 32'h11223344, 4'd5, 1'b0});
    res_q.push_back('{1'b0, 32'h0, 4'h0, 1'b0});
    res_q.push_back('{1'b1, 32'h11223344, 4'd5, 1'b0});
    res_q.push_back('{1'b0, 32'h0, 4'h0, 1'b0});
    @(negedge clk);
    ld_addr = 32'h10; ld_tag = 4'd5; st_addr = 32'h20; st_data = 32'hA5A5A5A5;
    ld_req = 1'b1; st_req = 1'b1;
    begin
      int acks = 0;
      bit done = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (ld_ack || st_ack) acks++;
        if (acks >= 4) begin ld_req = 1'b0; st_req = 1'b0; end
        if (acks >= 4 && !busy) begin done = 1'b1; break; end
      end
      ld_req = 1'b0; st_req = 1'b0;
      chk("contention_done", done, 1);
    end

    do_load(32'h20, 4'd6, 32'hA5A5A5A5, 1'b0, 1'b1);
    do_load(32'h40, 4'd4, 32'hCAFEF00D, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    chk("ack_queue_empty", ack_q.size(), 0);
    chk("res_queue_empty", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
